phase_spike_decoder: RTL

Receive-side counterpart of the phase-coded neuron. The block timestamps the first spike of each channel against the gamma oscillator phase and, at every gamma cycle boundary, converts each captured phase back into an input-current estimate: current ≈ THRESHOLD / (phase+1). Results leave one channel at a time over a valid/ready stream. It sits between the phase_neuron array and downstream attention/readout logic, next to the coincidence detectors.

---
 rtl/phase_dec_pkg.sv | 34 +++
 rtl/phase_recip_div.sv | 80 ++++++++
 rtl/phase_spike_decoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_dec_pkg.sv
// -----------------------------------------------------------------------------
// phase_dec_pkg
// Shared types and constants for the phase-coded spike decoder:
//   - dec_state_e : decode FSM states (IDLE, LOAD, DIV, EMIT)
//   - CUR_W       : width of the decoded current estimate
//   - DEF_*       : default threshold and gamma phase width
//   - chan_rec_t  : one channel's captured {phase, fired} record
// -----------------------------------------------------------------------------
package phase_dec_pkg;

  localparam int CUR_W         = 8;
  localparam int DEF_THRESHOLD = 200;
  localparam int DEF_PHASE_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2,
    ST_EMIT = 2'd3
  } dec_state_e;

  // Phase is stored at the full 8-bit divisor range, so a gamma phase of up to
  // 8 bits always fits.
  typedef struct packed {
    logic [DEF_PHASE_W-1:0] phase;
    logic                   fired;
  } chan_rec_t;

  // Divisor for a captured phase: phase+1, which spans 1..256.
  function automatic logic [CUR_W:0] recip_divisor(input logic [DEF_PHASE_W-1:0] phase);
    return {1'b0, phase} + (CUR_W+1)'(1);
  endfunction

endpackage

// File: rtl/phase_recip_div.sv
// -----------------------------------------------------------------------------
// phase_recip_div
// Serial restoring divider: CUR_W-bit dividend by (CUR_W+1)-bit divisor, one
// quotient bit per clock. A start pulse loads the operands; CUR_W edges later
// the quotient is final and stays held until the next start.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : load dividend/divisor and begin a division
//   dividend   : CUR_W-bit numerator
//   divisor    : (CUR_W+1)-bit denominator, never zero
//   done       : high during the last iteration (quotient valid after this edge)
//   quotient   : floor(dividend/divisor)
// -----------------------------------------------------------------------------
module phase_recip_div
  import phase_dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CUR_W-1:0] dividend,
  input  logic [CUR_W:0]   divisor,
  output logic             done,
  output logic [CUR_W-1:0] quotient
);

  logic [CUR_W:0]   rem_q, rem_d;
  logic [CUR_W:0]   dvs_q, dvs_d;
  logic [CUR_W-1:0] quo_q, quo_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CUR_W+1:0] shifted;
  logic [CUR_W:0]   trial;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rem_d = rem_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    // Partial remainder shifted left with the next dividend bit brought in.
    shifted = {rem_q, quo_q[CUR_W-1]};
    // Modular subtract is exact whenever shifted >= divisor (result < divisor).
    trial   = shifted[CUR_W:0] - dvs_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = 4'(CUR_W);
    end else if (cnt_q != 4'd0) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = trial;
        quo_d = {quo_q[CUR_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[CUR_W:0];
        quo_d = {quo_q[CUR_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign done     = (cnt_q == 4'd1);
  assign quotient = quo_q;

endmodule

// File: rtl/phase_spike_decoder.sv
// -----------------------------------------------------------------------------
// phase_spike_decoder
// Timestamps the first spike of each channel against the gamma phase and, at
// every gamma cycle boundary, decodes each captured phase into a current
// estimate THRESHOLD/(phase+1). Results leave one channel at a time, in
// ascending channel order, over a valid/ready stream.
//
// Build option: define PHASE_DEC_SKIP_SILENT_EN to emit only channels that
// fired; by default every channel is emitted (silent ones as current 0).
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   global_phase  : gamma phase (PHASE_W <= 8 bits)
//   cycle_start   : one-cycle pulse at phase 0 of a new gamma cycle
//   spike_in      : per-channel spike pulses
//   out_valid     : result available (EMIT)
//   out_ready     : downstream accepts the result
//   out_ch        : channel index of the result
//   out_current   : decoded current estimate
//   out_fired     : channel spiked in the decoded cycle
//   busy          : decode FSM not IDLE
//   overrun       : one-cycle pulse, an ended cycle was dropped
// -----------------------------------------------------------------------------
module phase_spike_decoder
  import phase_dec_pkg::*;
#(
  parameter  int NUM_CH    = 3,
  parameter  int THRESHOLD = DEF_THRESHOLD,
  parameter  int PHASE_W   = DEF_PHASE_W,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] global_phase,
  input  logic               cycle_start,
  input  logic [NUM_CH-1:0]  spike_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [CUR_W-1:0]   out_current,
  output logic               out_fired,
  output logic               busy,
  output logic               overrun
);

`ifdef PHASE_DEC_SKIP_SILENT_EN
  localparam bit SKIP_SILENT = 1'b1;
`else
  localparam bit SKIP_SILENT = 1'b0;
`endif

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  dec_state_e       state_q, state_d;
  chan_rec_t        cap_q  [NUM_CH];
  chan_rec_t        cap_d  [NUM_CH];
  chan_rec_t        snap_q [NUM_CH];
  chan_rec_t        snap_d [NUM_CH];
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             fired_q, fired_d;
  logic             overrun_q, overrun_d;

  logic                   load_hit;
  logic [CH_W-1:0]        load_idx;
  logic [DEF_PHASE_W-1:0] load_phase;
  logic                   more_after;

  logic             div_start;
  logic             div_done;
  logic [CUR_W-1:0] div_quotient;

  // ---------------------------------------------------------------------------
  // Capture: first spike per channel per gamma cycle. cycle_start clears the
  // bank first, so a spike on the same edge lands in the new cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cap_d[i] = cap_q[i];
      if (cycle_start) cap_d[i] = '0;
      if (spike_in[i] && !cap_d[i].fired) begin
        cap_d[i].fired = 1'b1;
        cap_d[i].phase = DEF_PHASE_W'(global_phase);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel selection for LOAD. Default build: the current channel. Skip build:
  // the lowest fired channel at or above the current one. more_after tells
  // EMIT whether any fired channel remains above the one being emitted.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_hit   = 1'b0;
    load_idx   = ch_q;
    more_after = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (snap_q[i].fired && (CH_W'(i) > ch_q)) more_after = 1'b1;
      if (SKIP_SILENT) begin
        if (snap_q[i].fired && (CH_W'(i) >= ch_q)) begin
          load_hit = 1'b1;
          load_idx = CH_W'(i);
        end
      end else if (CH_W'(i) == ch_q) begin
        load_hit = snap_q[i].fired;
      end
    end
  end

  always_comb begin
    load_phase = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == load_idx) load_phase = snap_q[i].phase;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    fired_d   = fired_q;
    snap_d    = snap_q;
    div_start = 1'b0;
    // A boundary while decoding drops the ended cycle; capture still clears.
    overrun_d = cycle_start && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (cycle_start) begin
          snap_d  = cap_q;
          ch_d    = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_hit) begin
          ch_d      = load_idx;
          fired_d   = 1'b1;
          div_start = 1'b1;
          state_d   = ST_DIV;
        end else if (SKIP_SILENT) begin
          state_d = ST_IDLE;
        end else begin
          fired_d = 1'b0;
          state_d = ST_EMIT;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          // Leave straight to IDLE on the final transfer so busy drops there.
          if ((ch_q == LAST_CH) || (SKIP_SILENT && !more_after)) begin
            state_d = ST_IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the capture and snapshot banks are a handful of flops rather than a
  // RAM, so they are cleared by reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      fired_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cap_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      fired_q   <= fired_d;
      overrun_q <= overrun_d;
      cap_q     <= cap_d;
      snap_q    <= snap_d;
    end
  end

  phase_recip_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (CUR_W'(THRESHOLD)),
    .divisor  (recip_divisor(load_phase)),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // The divider holds its quotient until the next start, so the payload is
  // stable for as long as EMIT is stalled.
  assign out_valid   = (state_q == ST_EMIT);
  assign out_ch      = ch_q;
  assign out_fired   = fired_q;
  assign out_current = fired_q ? div_quotient : '0;
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = overrun_q;

endmodule
